cla_serial_subtractor: RTL

Byte-serial multi-precision subtractor, the inverse-direction companion to the team's 8-bit carry-lookahead adder. Accepts operand pairs one byte per beat, least-significant byte first, and returns difference bytes (A − B) with the borrow carried between beats in a register. It computes each byte with the same generate/propagate lookahead structure, applied to A and inverted B. Valid/ready streams on both sides, plus final-beat status flags (borrow, zero, signed overflow).

---
 rtl/cla_serial_subtractor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cla_serial_subtractor.sv
// Byte-serial multi-precision subtractor (A - B), LSB slice first, borrow chained in a register.
// Each slice uses flat carry-lookahead over A and inverted B; one registered output stage.
module cla_serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_first,
    input  logic             i_in_last,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    output logic             o_borrow_out,
    output logic             o_zero,
    output logic             o_ovf
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHAIN = 1'b1;

    // Flat sum-of-products: c[i] = g[i] | g[j]&p[j+1..i] ... | cin&p[0..i].
    function automatic logic [WIDTH-1:0] lookahead(input logic [WIDTH-1:0] g,
                                                   input logic [WIDTH-1:0] p,
                                                   input logic             cin);
        logic [WIDTH-1:0] c;
        logic             prod;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = -1; j <= i; j++) begin
                prod = (j < 0) ? cin : g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                c[i] = c[i] | prod;
            end
        end
        return c;
    endfunction

    logic [0:0]       r_state;
    logic             r_borrow;
    logic             r_zacc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_borrow_out;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_start;
    logic             w_cin;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_zacc;
    logic             w_ovf;

    assign o_in_ready = ~r_out_valid | i_out_ready;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_start    = i_in_first | (r_state == ST_IDLE);
    assign w_cin      = w_start ? 1'b1 : ~r_borrow;

    always_comb begin
        w_g   = i_a & ~i_b;
        w_p   = i_a ^ ~i_b;
        w_c   = lookahead(w_g, w_p, w_cin);
        w_sum = w_p ^ {w_c[WIDTH-2:0], w_cin};
    end

    // Output index register doubles as the chain's previous-beat index.
    assign w_idx  = w_start ? '0 : r_out_idx + 1'b1;
    assign w_zacc = (w_sum == '0) & (w_start | r_zacc);
    assign w_ovf  = w_c[WIDTH-1] ^ w_c[WIDTH-2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_borrow     <= 1'b0;
            r_zacc       <= 1'b1;
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (w_accept) begin
            r_state      <= i_in_last ? ST_IDLE : ST_CHAIN;
            r_borrow     <= ~w_c[WIDTH-1];
            r_zacc       <= w_zacc;
            r_out_valid  <= 1'b1;
            r_diff       <= w_sum;
            r_out_idx    <= w_idx;
            r_out_last   <= i_in_last;
            r_borrow_out <= i_in_last & ~w_c[WIDTH-1];
            r_zero       <= i_in_last & w_zacc;
            r_ovf        <= i_in_last & w_ovf;
        end else if (i_out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_diff       = r_diff;
    assign o_out_idx    = r_out_idx;
    assign o_out_last   = r_out_last;
    assign o_borrow_out = r_borrow_out;
    assign o_zero       = r_zero;
    assign o_ovf        = r_ovf;

endmodule
